polybius_enc_ctrl: RTL and testbench

Sequencing controller for the Polybius-square encryptor core. It collects a MSG_LEN-character plaintext message over a valid/ready input stream. It then hands the characters to the encryptor core one at a time through a req/ack handshake, rotating the key index over SEC_LEN. Finally it streams the resulting row-column codes (row*10+col, digits 1..5) out over valid/ready with a last marker and an error flag.

---
 rtl/polybius_pkg.sv | 23 ++
 rtl/polybius_code_check.sv | 20 ++
 rtl/polybius_enc_ctrl.sv | 143 ++++++++++++++
 tb/tb_polybius_enc_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/polybius_pkg.sv
// Shared types, constants and the row/column digit check for the Polybius encryptor controller.
package polybius_pkg;

   localparam logic [7:0] GRID_DIM  = 8'd5;
   localparam logic [7:0] CODE_BASE = 8'd10;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      ENC  = 2'd1,
      EMIT = 2'd2
   } ctrl_state_e;

   // A legal code is row*10+col with both digits in 1..GRID_DIM.
   function automatic logic code_valid(input logic [7:0] code);
      logic [7:0] tens;
      logic [7:0] units;
      tens  = code / CODE_BASE;
      units = code % CODE_BASE;
      return (tens >= 8'd1) && (tens <= GRID_DIM) &&
             (units >= 8'd1) && (units <= GRID_DIM);
   endfunction

endpackage

// File: rtl/polybius_code_check.sv
// Combinational check of a core result: flags legal codes and zeroes illegal ones.
module polybius_code_check
   import polybius_pkg::*;
(
   input  logic [7:0] code,
   output logic       valid,
   output logic [7:0] clean_code
);

   // Sanitize here so the capture path only ever stores a legal code or zero.
   always_comb begin
      valid = code_valid(code);
      if (valid) begin
         clean_code = code;
      end else begin
         clean_code = 8'd0;
      end
   end

endmodule

// File: rtl/polybius_enc_ctrl.sv
// Sequencing controller: loads a message, feeds it through the encryptor core with a
// rotating key index, then streams the row/column codes out with last and error markers.
module polybius_enc_ctrl
   import polybius_pkg::*;
#(
   parameter  int MSG_LEN = 6,
   parameter  int SEC_LEN = 3,
   localparam int KW      = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_char,
   output logic          core_req,
   output logic [7:0]    core_char,
   output logic [KW-1:0] core_key_idx,
   input  logic          core_ack,
   input  logic [7:0]    core_code,
   input  logic          core_err,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_code,
   output logic          out_last,
   output logic          err,
   output logic          busy
);

   localparam int            IW        = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam logic [IW-1:0] IDX_LAST  = IW'(MSG_LEN - 1);
   localparam logic [KW-1:0] KIDX_LAST = KW'(SEC_LEN - 1);
   localparam logic [1:0]    ST_LOAD   = 2'(LOAD);
   localparam logic [1:0]    ST_ENC    = 2'(ENC);
   localparam logic [1:0]    ST_EMIT   = 2'(EMIT);

   logic [1:0]    state_r;
   logic [IW-1:0] idx_r;
   logic [KW-1:0] kidx_r;
   logic          err_r;
   logic [7:0]    buf_r [MSG_LEN];

   logic          load_s;
   logic          enc_s;
   logic          emit_s;
   logic          idx_last_s;
   logic          chk_valid_s;
   logic [7:0]    chk_code_s;
   logic          ack_ok_s;
   logic [7:0]    cap_code_s;

   polybius_code_check u_code_check (
      .code       (core_code),
      .valid      (chk_valid_s),
      .clean_code (chk_code_s)
   );

   // State decode and the value written back into the buffer on a core ack.
   always_comb begin
      load_s     = (state_r == ST_LOAD);
      enc_s      = (state_r == ST_ENC);
      emit_s     = (state_r == ST_EMIT);
      idx_last_s = (idx_r == IDX_LAST);
      if (!core_err && chk_valid_s) begin
         ack_ok_s   = 1'b1;
         cap_code_s = chk_code_s;
      end else begin
         ack_ok_s   = 1'b0;
         cap_code_s = 8'd0;
      end
   end

   // Handshake outputs are forced low while reset is asserted.
   assign in_ready     = !rst && load_s;
   assign core_req     = !rst && enc_s;
   assign core_char    = buf_r[idx_r];
   assign core_key_idx = kidx_r;
   assign out_valid    = !rst && emit_s;
   assign out_code     = buf_r[idx_r];
   assign out_last     = !rst && emit_s && idx_last_s;
   assign err          = !rst && emit_s && err_r;
   assign busy         = !rst && !load_s;

   // State, counters, the shared message buffer and the sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_LOAD;
         idx_r   <= '0;
         kidx_r  <= '0;
         err_r   <= 1'b0;
         for (int i = 0; i < MSG_LEN; i++) begin
            buf_r[i] <= 8'd0;
         end
      end else begin
         case (state_r)
            ST_LOAD: begin
               if (in_valid) begin
                  buf_r[idx_r] <= in_char;
                  if (idx_last_s) begin
                     state_r <= ST_ENC;
                     idx_r   <= '0;
                     kidx_r  <= '0;
                  end else begin
                     idx_r <= idx_r + IW'(1);
                  end
               end
            end
            ST_ENC: begin
               if (core_ack) begin
                  buf_r[idx_r] <= cap_code_s;
                  if (!ack_ok_s) begin
                     err_r <= 1'b1;
                  end
                  if (idx_last_s) begin
                     state_r <= ST_EMIT;
                     idx_r   <= '0;
                  end else begin
                     idx_r  <= idx_r + IW'(1);
                     kidx_r <= (kidx_r == KIDX_LAST) ? '0 : kidx_r + KW'(1);
                  end
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  if (idx_last_s) begin
                     state_r <= ST_LOAD;
                     idx_r   <= '0;
                     err_r   <= 1'b0;
                  end else begin
                     idx_r <= idx_r + IW'(1);
                  end
               end
            end
            default: begin
               state_r <= ST_LOAD;
               idx_r   <= '0;
               kidx_r  <= '0;
               err_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_polybius_enc_ctrl.sv
// Directed bench for polybius_enc_ctrl: a letter-level Polybius core model, a queue of
// expected codes compared every output cycle, and literal code/key sequences per test.
module tb_polybius_enc_ctrl;

   localparam int MSG_LEN = 6;
   localparam int SEC_LEN = 3;
   localparam int KW      = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_char;
   logic          core_req;
   logic [7:0]    core_char;
   logic [KW-1:0] core_key_idx;
   logic          core_ack;
   logic [7:0]    core_code;
   logic          core_err;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_code;
   logic          out_last;
   logic          err;
   logic          busy;

   polybius_enc_ctrl #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
      .core_req(core_req), .core_char(core_char), .core_key_idx(core_key_idx),
      .core_ack(core_ack), .core_code(core_code), .core_err(core_err),
      .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
      .out_last(out_last), .err(err), .busy(busy)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [7:0]    tx      [0:11];
   logic [9:0]    exp_arr [0:127];
   logic [7:0]    obs     [0:255];
   logic [KW-1:0] key_log [0:255];
   int exp_wr = 0, exp_rd = 0, obs_n = 0, key_n = 0;
   int acc_cnt = 0, req_cyc = 0, last_acc_cyc = 0, ov_rise_cyc = 0, msg_xfer = 0;
   int core_delay = 0, core_idx = 0, ready_mode = 0;
   logic [7:0] inj_err_char = 8'h00;
   logic [7:0] inj_bad_char = 8'h00;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name, input int waited);
      n_vec++;
      n_err++;
      $display("FAIL %s: gave up after %0d cycles, required the event to occur", name, waited);
   endtask

   // Standard 5x5 Polybius square, J sharing the I cell; non-letters map to 0.
   function automatic logic [7:0] polyb(input logic [7:0] c);
      int p;
      if (c < 8'd65 || c > 8'd90) return 8'd0;
      p = int'(c) - 65;
      if (c == 8'd74) p = 8;
      else if (c > 8'd74) p = p - 1;
      return 8'((p / 5 + 1) * 10 + p % 5 + 1);
   endfunction

   function automatic bit model_ok(input logic [7:0] v);
      int t;
      int u;
      t = int'(v) / 10;
      u = int'(v) % 10;
      return (t >= 1) && (t <= 5) && (u >= 1) && (u <= 5);
   endfunction

   function automatic logic [7:0] core_resp(input logic [7:0] c);
      return (c == inj_bad_char) ? 8'd60 : polyb(c);
   endfunction

   task automatic load_tx(input string s);
      for (int i = 0; i < s.len(); i++) tx[i] = s[i];
   endtask

   task automatic push_msg(input int first);
      logic [7:0] code [MSG_LEN];
      bit         bad  [MSG_LEN];
      bit         any;
      any = 1'b0;
      for (int i = 0; i < MSG_LEN; i++) begin
         code[i] = core_resp(tx[first + i]);
         bad[i]  = (tx[first + i] == inj_err_char) || !model_ok(code[i]);
         any     = any | bad[i];
      end
      for (int i = 0; i < MSG_LEN; i++) begin
         exp_arr[exp_wr] = {any, 1'(i == MSG_LEN - 1), bad[i] ? 8'd0 : code[i]};
         exp_wr++;
      end
   endtask

   task automatic send(input int first, input int n, input bit hold);
      int t;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_char  = tx[first + i];
         t = 0;
         @(negedge clk);
         while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) fail_now("input_accept_timeout", t);
         @(posedge clk);
         #1;
      end
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_rd != exp_wr && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (exp_rd != exp_wr) fail_now("output_drain_timeout", t);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic chk_codes(input string name, input int base, input int e [MSG_LEN]);
      for (int i = 0; i < MSG_LEN; i++) chk(name, 32'(obs[base + i]), e[i]);
   endtask

   // Core model: answers each request after core_delay extra cycles and checks the request.
   initial begin
      int         wait_cnt;
      logic [7:0] held_char;
      logic [KW-1:0] held_key;
      wait_cnt = 0;
      held_char = 8'd0;
      held_key = '0;
      core_ack = 1'b0;
      core_code = 8'd0;
      core_err = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            core_idx = 0;
            wait_cnt = 0;
         end else if (core_req) begin
            if (wait_cnt == 0) begin
               held_char = core_char;
               held_key  = core_key_idx;
            end else begin
               chk("core_char_stable", core_char, held_char);
               chk("core_key_stable", core_key_idx, held_key);
            end
            if (wait_cnt == core_delay) begin
               chk("core_key_idx", core_key_idx, core_idx % SEC_LEN);
               key_log[key_n] = core_key_idx;
               key_n++;
               core_code = core_resp(core_char);
               core_err  = (core_char == inj_err_char);
               core_ack  = 1'b1;
               core_idx  = (core_idx == MSG_LEN - 1) ? 0 : core_idx + 1;
               wait_cnt  = 0;
               @(posedge clk);
               #1;
               core_ack  = 1'b0;
               core_err  = 1'b0;
               core_code = 8'd0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Downstream: always ready, or a 3-cycle stall on the third code then random toggling.
   initial begin
      int stall_left;
      stall_left = 3;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0) begin
            out_ready  = 1'b1;
            stall_left = 3;
         end else if (out_valid && msg_xfer == 2 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else if (stall_left == 0) begin
            out_ready = 1'($urandom_range(0, 1));
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Output compare against the expected-code queue, plus accept/request bookkeeping.
   initial begin
      logic [9:0] e;
      bit         ov_prev;
      ov_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ov_prev  = 1'b0;
            msg_xfer = 0;
         end else begin
            chk("in_ready_vs_busy", in_ready, !busy);
            if (in_valid && in_ready) begin
               acc_cnt++;
               last_acc_cyc = cyc;
            end
            if (core_req) req_cyc++;
            if (out_valid) begin
               if (!ov_prev) ov_rise_cyc = cyc;
               if (exp_rd == exp_wr) begin
                  chk("unexpected_out_valid", out_valid, 1'b0);
               end else begin
                  e = exp_arr[exp_rd];
                  chk("out_code", out_code, e[7:0]);
                  chk("out_last", out_last, e[8]);
                  chk("err", err, e[9]);
                  if (out_ready) begin
                     obs[obs_n] = out_code;
                     obs_n++;
                     exp_rd++;
                     msg_xfer = out_last ? 0 : msg_xfer + 1;
                  end
               end
            end
            ov_prev = out_valid;
         end
      end
   end

   initial begin
      #2000000;
      n_err++;
      $display("FAIL watchdog: reached cycle %0d, required the bench to finish earlier", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int kbase;
      int rbase;
      int t;
      rst = 1'b1;
      in_valid = 1'b0;
      in_char = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_core_req", core_req, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_reset", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // Nominal message, core answers after 2 extra cycles.
      core_delay = 2;
      load_tx("ABCDEF");
      base = obs_n;
      kbase = key_n;
      push_msg(0);
      send(0, MSG_LEN, 1'b0);
      drain();
      chk_codes("nominal_code", base, '{11, 12, 13, 14, 15, 21});
      for (int i = 0; i < MSG_LEN; i++) chk("nominal_key_seq", key_log[kbase + i], i % SEC_LEN);

      // Zero-wait core: exact ENC length and first-output latency.
      core_delay = 0;
      load_tx("GHIKLM");
      base = obs_n;
      rbase = req_cyc;
      push_msg(0);
      send(0, MSG_LEN, 1'b0);
      drain();
      chk("enc_cycles", req_cyc - rbase, MSG_LEN);
      chk("first_out_latency", ov_rise_cyc - last_acc_cyc, MSG_LEN + 1);
      chk_codes("zero_wait_code", base, '{22, 23, 24, 25, 31, 32});

      // Backpressure on the third code, then random out_ready.
      core_delay = 1;
      ready_mode = 1;
      load_tx("ABCDEF");
      base = obs_n;
      push_msg(0);
      send(0, MSG_LEN, 1'b0);
      drain();
      ready_mode = 0;
      chk_codes("backpressure_code", base, '{11, 12, 13, 14, 15, 21});

      // Core error on 'C', out-of-range 60 on 'E'; the following message must be clean.
      inj_err_char = 8'h43;
      inj_bad_char = 8'h45;
      load_tx("ABCDEF");
      base = obs_n;
      push_msg(0);
      send(0, MSG_LEN, 1'b0);
      drain();
      chk_codes("error_code", base, '{11, 12, 0, 14, 0, 21});
      inj_err_char = 8'h00;
      inj_bad_char = 8'h00;
      load_tx("FEDCBA");
      base = obs_n;
      push_msg(0);
      send(0, MSG_LEN, 1'b0);
      drain();
      chk_codes("after_error_code", base, '{21, 15, 14, 13, 12, 11});

      // Reset while waiting for the ack of the fourth character.
      core_delay = 6;
      load_tx("ABCDEF");
      send(0, MSG_LEN, 1'b0);
      t = 0;
      while (!(core_idx == 3 && core_req) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!(core_idx == 3 && core_req)) fail_now("mid_enc_wait_timeout", t);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_core_req", core_req, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_core_req", core_req, 1'b0);
      chk("post_rst_out_valid", out_valid, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_in_ready", in_ready, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      core_delay = 0;
      load_tx("GHIKLM");
      base = obs_n;
      push_msg(0);
      send(0, MSG_LEN, 1'b0);
      drain();
      chk_codes("post_rst_code", base, '{22, 23, 24, 25, 31, 32});

      // Back-to-back messages with in_valid held high throughout.
      core_delay = 1;
      load_tx("ABCDEFNOPQRS");
      base = obs_n;
      rbase = acc_cnt;
      push_msg(0);
      push_msg(MSG_LEN);
      send(0, 2 * MSG_LEN, 1'b1);
      in_valid = 1'b0;
      drain();
      chk("b2b_accepts", acc_cnt - rbase, 2 * MSG_LEN);
      chk_codes("b2b_first_code", base, '{11, 12, 13, 14, 15, 21});
      chk_codes("b2b_second_code", base + MSG_LEN, '{33, 34, 35, 41, 42, 43});

      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
